// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: in-order request queue feeding a single multi-cycle div/rem
// unit, with one op in flight and its result broadcast on the CDB.
module md_issue_ctrl #(
    parameter int PHYS_REG_BITS = 6,
    parameter int ROB_BITS      = 5,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [2:0]               i_req_funct3,
    input  logic [31:0]              i_req_rs1_v,
    input  logic [31:0]              i_req_rs2_v,
    input  logic [PHYS_REG_BITS-1:0] i_req_pd,
    input  logic [ROB_BITS-1:0]      i_req_rob_idx,
    output logic                     o_fu_start,
    output logic [2:0]               o_fu_funct3,
    output logic [31:0]              o_fu_rs1_v,
    output logic [31:0]              o_fu_rs2_v,
    input  logic                     i_fu_valid,
    input  logic [31:0]              i_fu_rd_v,
    output logic                     o_cdb_valid,
    input  logic                     i_cdb_ready,
    output logic [31:0]              o_cdb_rd_v,
    output logic [PHYS_REG_BITS-1:0] o_cdb_pd,
    output logic [ROB_BITS-1:0]      o_cdb_rob_idx
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [2:0]               funct3;
        logic [31:0]              rs1;
        logic [31:0]              rs2;
        logic [PHYS_REG_BITS-1:0] pd;
        logic [ROB_BITS-1:0]      rob;
    } op_t;

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    op_t          r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    state_t       r_state, w_next;
    op_t          r_op;
    logic [31:0]  r_res;

    logic w_clr, w_push, w_pop;
    op_t  w_req;

    // Flush and reset share one clear path; flush also kills a same-cycle push.
    assign w_clr       = rst | i_flush;
    assign o_req_ready = !rst && (r_count < CW'(DEPTH));
    assign w_push      = i_req_valid && o_req_ready && !i_flush;
    assign w_pop       = (r_state == IDLE) && (r_count != '0) && !w_clr;
    assign w_req       = '{funct3: i_req_funct3, rs1: i_req_rs1_v, rs2: i_req_rs2_v,
                           pd: i_req_pd, rob: i_req_rob_idx};

    // Queue storage; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_req;
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Op and result registers: head is latched on pop, result on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op  <= '0;
            r_res <= '0;
        end else begin
            if (w_pop) r_op <= r_mem[r_rptr];
            if (r_state == WAIT && i_fu_valid && !i_flush) r_res <= i_fu_rd_v;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and outputs; stray completions outside WAIT are ignored.
    always_comb begin
        w_next        = r_state;
        o_fu_start    = 1'b0;
        o_cdb_valid   = 1'b0;
        o_fu_funct3   = '0;
        o_fu_rs1_v    = '0;
        o_fu_rs2_v    = '0;
        o_cdb_rd_v    = '0;
        o_cdb_pd      = '0;
        o_cdb_rob_idx = '0;
        if (r_state != IDLE) begin
            o_fu_funct3 = r_op.funct3;
            o_fu_rs1_v  = r_op.rs1;
            o_fu_rs2_v  = r_op.rs2;
        end
        case (r_state)
            IDLE:  if (r_count != '0) w_next = START;
            START: begin
                o_fu_start = 1'b1;
                w_next     = WAIT;
            end
            WAIT:  if (i_fu_valid) w_next = RESP;
            RESP: begin
                o_cdb_valid   = 1'b1;
                o_cdb_rd_v    = r_res;
                o_cdb_pd      = r_op.pd;
                o_cdb_rob_idx = r_op.rob;
                if (i_cdb_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_clr) w_next = IDLE;
    end

endmodule
